axis_dest_demux: RTL
====================

AXIS_DEST_DEMUX -- requirements
Module: axis_dest_demux

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- AXIS_DATA_WIDTH, 64, tdata width.
- AXIS_KEEP_WIDTH, AXIS_DATA_WIDTH/8, tkeep width.
- AXIS_DEST_WIDTH, 3, tdest width.
- M_COUNT, 4, number of output ports, 1..2**AXIS_DEST_WIDTH.
REQ-002 Ports (name, direction, width, meaning), one per line:
- clk, in, 1, single clock; all logic rising-edge.
- rst, in, 1, asynchronous active-high reset.
- s_axis_tdata, in, AXIS_DATA_WIDTH, input data.
- s_axis_tkeep, in, AXIS_KEEP_WIDTH, input byte enables.
- s_axis_tdest, in, AXIS_DEST_WIDTH, destination, valid on first beat only.
- s_axis_tlast, in, 1, end of frame.
- s_axis_tvalid, in, 1, input valid.
- s_axis_tready, out, 1, input ready.
- m_axis_tdata, out, AXIS_DATA_WIDTH, shared output data.
- m_axis_tkeep, out, AXIS_KEEP_WIDTH, shared output keep.
- m_axis_tlast, out, 1, shared output last.
- m_axis_tvalid, out, M_COUNT, per-port valid, at most one bit set.
- m_axis_tready, in, M_COUNT, per-port ready.
- rst_drop_counter, in, 1, synchronous clear of drop_count.
- drop_count, out, 32, frames dropped for invalid destination.
- fwd_count, out, 32, frames forwarded (tlast beat accepted into output register).
REQ-003 Reset is asynchronous, active-high, on rst; clock is clk.

Function
REQ-004 States: IDLE (awaiting first beat), FORWARD (mid-frame to latched port), DROP (discarding mid-frame).
REQ-005 Output register: one beat deep; holds data, keep, last, valid flag out_v and port index out_port.
REQ-006 drain = out_v AND m_axis_tready[out_port]; s_axis_tready = NOT out_v OR drain, except in DROP, where it is 1.
REQ-007 m_axis_tvalid[i] = out_v AND (out_port == i); all other bits are 0.
REQ-008 IDLE, beat accepted, s_axis_tdest < M_COUNT:
- load the output register with out_port = s_axis_tdest;
- latch the port into cur_port;
- go to FORWARD unless s_axis_tlast, which stays in IDLE.
REQ-009 IDLE, s_axis_tvalid, s_axis_tdest >= M_COUNT:
- beat is consumed with s_axis_tready = 1 and never reaches the outputs;
- drop_count increments;
- go to DROP unless s_axis_tlast.
REQ-010 FORWARD: each accepted beat loads the output register with out_port = cur_port; s_axis_tdest is ignored; tlast accepted -> IDLE.
REQ-011 DROP: every beat consumed and discarded; tlast -> IDLE; drop_count increments only once per frame, in IDLE.
REQ-012 Load and drain in the same cycle: new beat replaces old and out_v stays 1, giving full throughput when the port is ready.
REQ-013 Frame boundary: the first beat of frame N+1 may load while the last beat of frame N drains, even to a different port.
REQ-014 Latency: an accepted beat appears on m_axis_* the next cycle; zero bubbles while the selected tready stays high.
REQ-015 No drain and no load: out_v and the output register hold; data and port are stable while valid is asserted.
REQ-016 Counters saturate at 0xFFFFFFFF.
REQ-017 rst_drop_counter clears drop_count next cycle and has priority over a simultaneous increment; fwd_count is unaffected.
REQ-018 fwd_count increments when a tlast beat loads the output register.
REQ-019 Inputs are sampled only on the s_axis_tvalid AND s_axis_tready handshake; other values are don't-care.

Reset
REQ-020 On rst: state = IDLE, out_v = 0, all m_axis_tvalid = 0, out_port = 0, cur_port = 0, drop_count = 0, fwd_count = 0.
REQ-021 m_axis_tdata, m_axis_tkeep and m_axis_tlast reset to 0.
REQ-022 Reset mid-frame abandons the frame with no output emitted; the next beat after release is treated as a first beat.

Verification
REQ-023 3-beat frame, tdest = 2, all ready: m_axis_tvalid = 4'b0100 for 3 consecutive cycles starting 1 cycle after the first beat; tlast on beat 3; fwd_count = 1.
REQ-024 Frame tdest = 5 with M_COUNT = 4, 4 beats: s_axis_tready = 1 throughout; m_axis_tvalid stays 0; drop_count = 1.
REQ-025 Back-to-back 1-beat frames to ports 0 then 3, ready high: m_axis_tvalid = 0001 then 1000 on consecutive cycles with no bubble.
REQ-026 Port 1 tready low for 5 cycles mid-frame: s_axis_tready = 0 after one buffered beat; data held stable; resumes with no loss or duplication.
REQ-027 rst_drop_counter asserted in the same cycle as an invalid first beat: drop_count = 0 next cycle.
REQ-028 rst asserted during beat 2 of a 4-beat frame: all outputs 0; the next frame (tdest = 0) routes correctly to port 0.

Source files
------------

// File: rtl/axis_dest_demux.sv
// axis_dest_demux: routes each AXI-Stream frame to the output port named by the tdest of its first
//   beat. Frames with an out-of-range tdest are consumed and counted. Beats go through a single
//   shared one-beat output register.
// Latency: an accepted beat appears on m_axis_* the following cycle. With the selected port ready,
//   the module runs at full throughput, including across frame boundaries.
// Backpressure: s_axis_tready follows the output register (empty, or draining this cycle). While a
//   frame is being discarded, s_axis_tready is forced high.
// Ports:
//   clk, rst (async, active-high)
//   s_axis_*: input stream; tdest is sampled on the first beat only
//   m_axis_tdata/tkeep/tlast: shared across all ports
//   m_axis_tvalid/tready: one bit per port; at most one tvalid bit is set at a time
//   rst_drop_counter: synchronous clear of drop_count
//   drop_count, fwd_count: saturating frame counters
module axis_dest_demux #(
  parameter int AXIS_DATA_WIDTH = 64,
  parameter int AXIS_KEEP_WIDTH = AXIS_DATA_WIDTH/8,
  parameter int AXIS_DEST_WIDTH = 3,
  parameter int M_COUNT         = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [AXIS_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [AXIS_KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic [AXIS_DEST_WIDTH-1:0] s_axis_tdest,
  input  logic                       s_axis_tlast,
  input  logic                       s_axis_tvalid,
  output logic                       s_axis_tready,
  output logic [AXIS_DATA_WIDTH-1:0] m_axis_tdata,
  output logic [AXIS_KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                       m_axis_tlast,
  output logic [M_COUNT-1:0]         m_axis_tvalid,
  input  logic [M_COUNT-1:0]         m_axis_tready,
  input  logic                       rst_drop_counter,
  output logic [31:0]                drop_count,
  output logic [31:0]                fwd_count
);

  typedef enum logic [1:0] {IDLE, FORWARD, DROP} state_t;

  // One extra bit so that M_COUNT == 2**AXIS_DEST_WIDTH is still representable.
  localparam logic [AXIS_DEST_WIDTH:0] DEST_LIM = (AXIS_DEST_WIDTH+1)'(M_COUNT);

  state_t                     state, state_next;
  logic                       out_v;
  logic [AXIS_DEST_WIDTH-1:0] out_port;
  logic [AXIS_DEST_WIDTH-1:0] cur_port;
  logic [AXIS_DEST_WIDTH-1:0] load_port;
  logic                       dest_ok;
  logic                       drain;
  logic                       buf_free;
  logic                       load;
  logic                       fwd_inc;
  logic                       drop_inc;

  assign dest_ok = {1'b0, s_axis_tdest} < DEST_LIM;

  always_comb begin
    for (int i = 0; i < M_COUNT; i++) begin
      m_axis_tvalid[i] = out_v && (out_port == AXIS_DEST_WIDTH'(i));
    end
  end

  // m_axis_tvalid has only the out_port bit set, so this equals tready[out_port].
  // It also avoids indexing tready with a port number wider than M_COUNT.
  assign drain    = |(m_axis_tvalid & m_axis_tready);
  assign buf_free = !out_v || drain;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next    = state;
    s_axis_tready = buf_free;
    load          = 1'b0;
    load_port     = cur_port;
    fwd_inc       = 1'b0;
    drop_inc      = 1'b0;
    case (state)
      IDLE: begin
        if (s_axis_tvalid && !dest_ok) begin
          // Unroutable first beat: swallow it at once, whatever the output register holds.
          s_axis_tready = 1'b1;
          drop_inc      = 1'b1;
          if (!s_axis_tlast) state_next = DROP;
        end else if (s_axis_tvalid && buf_free) begin
          load      = 1'b1;
          load_port = s_axis_tdest;
          fwd_inc   = s_axis_tlast;
          if (!s_axis_tlast) state_next = FORWARD;
        end
      end
      FORWARD: begin
        if (s_axis_tvalid && buf_free) begin
          load = 1'b1;
          if (s_axis_tlast) begin
            fwd_inc    = 1'b1;
            state_next = IDLE;
          end
        end
      end
      DROP: begin
        s_axis_tready = 1'b1;
        if (s_axis_tvalid && s_axis_tlast) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_v        <= 1'b0;
      out_port     <= '0;
      cur_port     <= '0;
      m_axis_tdata <= '0;
      m_axis_tkeep <= '0;
      m_axis_tlast <= 1'b0;
      drop_count   <= '0;
      fwd_count    <= '0;
    end else begin
      // A load on the same cycle as a drain replaces the old beat, and out_v stays high.
      if (load) begin
        out_v        <= 1'b1;
        out_port     <= load_port;
        cur_port     <= load_port;
        m_axis_tdata <= s_axis_tdata;
        m_axis_tkeep <= s_axis_tkeep;
        m_axis_tlast <= s_axis_tlast;
      end else if (drain) begin
        out_v <= 1'b0;
      end

      if (rst_drop_counter) begin
        drop_count <= '0;
      end else if (drop_inc && drop_count != 32'hFFFF_FFFF) begin
        drop_count <= drop_count + 32'd1;
      end

      if (fwd_inc && fwd_count != 32'hFFFF_FFFF) begin
        fwd_count <= fwd_count + 32'd1;
      end
    end
  end

endmodule
